// File: rtl/btn_debounce_pkg.sv
// ============================================================================
// btn_debounce_pkg : shared state encoding and defaults for the debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT1   = 2'd1,
    ST_PRESSED = 2'd2,
    ST_WAIT0   = 2'd3
  } db_state_e;

  // 20 ms at 50 MHz
  localparam int unsigned C_DB_CYCLES_DEFAULT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// btn_debounce_ch : one button channel - 2-flop sync, debounce FSM, counter
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = C_DB_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned      CNT_W  = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic             w_pin;
  logic [1:0]       r_sync;
  logic             w_s;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Normalised so that 1 always means pressed; reset loads the released level
  assign w_pin = ACTIVE_LOW ? ~i_btn : i_btn;
  assign w_s   = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], w_pin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Counter is reloaded on each WAIT entry and never runs past the terminal count
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt = ST_WAIT1;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT1: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == C_TERM) begin
          w_state_nxt = ST_PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_WAIT0;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT0: begin
        if (w_s) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_cnt == C_TERM) begin
          w_state_nxt   = ST_IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_level_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_WAIT0);
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : N independent debounced button channels with press/release ticks
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DB_CYCLES  = C_DB_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] db_level,
  output logic [N-1:0] press_tick,
  output logic [N-1:0] release_tick
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset_n),
      .i_btn     (btn[g]),
      .o_level   (db_level[g]),
      .o_press   (press_tick[g]),
      .o_release (release_tick[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ============================================================================
// tb_btn_debounce : scoreboard bench for btn_debounce (N=2, DB_CYCLES=8, active low)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_btn_debounce;
  import btn_debounce_pkg::*;

  localparam int unsigned C_N  = 2;
  localparam int unsigned C_DB = 8;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  press;
    logic [1:0]  rel;
    logic [1:0]  lvl;
  } exp_t;

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b0;
  logic [C_N-1:0] btn      = 2'b00;
  logic [C_N-1:0] db_level;
  logic [C_N-1:0] press_tick;
  logic [C_N-1:0] release_tick;

  int unsigned cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];
  logic [1:0]  prev_lvl   = 2'b00;
  logic [1:0]  prev_press = 2'b00;
  logic [1:0]  prev_rel   = 2'b00;

  btn_debounce #(
    .N          (C_N),
    .DB_CYCLES  (C_DB),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn          (btn),
    .db_level     (db_level),
    .press_tick   (press_tick),
    .release_tick (release_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A pin change driven now is first sampled at edge cyc+1 and the tick
  // registers two sync edges plus DB_CYCLES edges later.
  task automatic expect_tick(input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lvl);
    exp_t e;
    e.cyc   = cyc + 1 + 2 + C_DB;
    e.press = pr;
    e.rel   = rl;
    e.lvl   = lvl;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check_val("tick_excl", 32'(press_tick & release_tick), 32'd0);
      check_val("press_width", 32'(press_tick & prev_press), 32'd0);
      check_val("rel_width", 32'(release_tick & prev_rel), 32'd0);
      check_val("lvl_vs_tick", 32'(db_level ^ prev_lvl), 32'(press_tick | release_tick));
      check_val("cnt0_range", 32'(dut.g_ch[0].u_ch.r_cnt > 4'(C_DB - 1)), 32'd0);
      check_val("cnt1_range", 32'(dut.g_ch[1].u_ch.r_cnt > 4'(C_DB - 1)), 32'd0);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check_val("tick_missing", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      if ((press_tick | release_tick) != 2'b00) begin
        if (sb_q.size() == 0) begin
          check_val("tick_unexp", 32'({press_tick, release_tick}), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("tick_cyc", cyc, e.cyc);
          check_val("press_tick", 32'(press_tick), 32'(e.press));
          check_val("release_tick", 32'(release_tick), 32'(e.rel));
          check_val("db_level", 32'(db_level), 32'(e.lvl));
        end
      end
    end
    prev_lvl   = db_level;
    prev_press = press_tick;
    prev_rel   = release_tick;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Scenario 1: both held through reset, fresh press after release
    tick_wait(5);
    check_val("rst_level", 32'(db_level), 32'd0);
    check_val("rst_press", 32'(press_tick), 32'd0);
    check_val("rst_release", 32'(release_tick), 32'd0);
    reset_n = 1'b1;
    expect_tick(2'b11, 2'b00, 2'b11);
    tick_wait(20);
    check_val("s1_level", 32'(db_level), 32'h3);
    btn = 2'b11;
    expect_tick(2'b00, 2'b11, 2'b00);
    tick_wait(20);

    // Scenario 2: channel 0 press held 30 cycles, channel 1 untouched
    btn = 2'b10;
    expect_tick(2'b01, 2'b00, 2'b01);
    tick_wait(30);
    check_val("s2_level", 32'(db_level), 32'h1);
    btn = 2'b11;
    expect_tick(2'b00, 2'b01, 2'b00);
    tick_wait(20);

    // Scenario 3: 5-cycle bounce rejected
    btn = 2'b10;
    tick_wait(5);
    check_val("s3_level_mid", 32'(db_level), 32'd0);
    btn = 2'b11;
    tick_wait(10);
    check_val("s3_level", 32'(db_level), 32'd0);
    check_val("s3_idle", 32'(dut.g_ch[0].u_ch.r_state), 32'(ST_IDLE));

    // Scenario 4: release glitch ignored, genuine release later
    btn = 2'b10;
    expect_tick(2'b01, 2'b00, 2'b01);
    tick_wait(20);
    btn = 2'b11;
    tick_wait(3);
    btn = 2'b10;
    tick_wait(4);
    check_val("s4_level_glitch", 32'(db_level), 32'h1);
    btn = 2'b11;
    expect_tick(2'b00, 2'b01, 2'b00);
    tick_wait(20);

    // Scenario 5: simultaneous press and release on both channels
    btn = 2'b00;
    expect_tick(2'b11, 2'b00, 2'b11);
    tick_wait(20);
    btn = 2'b11;
    expect_tick(2'b00, 2'b11, 2'b00);
    tick_wait(20);

    // Scenario 6: reset while channel 0 is in WAIT1 at cnt=4
    btn = 2'b10;
    tick_wait(7);
    check_val("s6_state", 32'(dut.g_ch[0].u_ch.r_state), 32'(ST_WAIT1));
    check_val("s6_cnt", 32'(dut.g_ch[0].u_ch.r_cnt), 32'd4);
    reset_n = 1'b0;
    tick_wait(3);
    check_val("s6_rst_level", 32'(db_level), 32'd0);
    check_val("s6_rst_press", 32'(press_tick), 32'd0);
    check_val("s6_rst_state", 32'(dut.g_ch[0].u_ch.r_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    expect_tick(2'b01, 2'b00, 2'b01);
    tick_wait(20);
    btn = 2'b11;
    expect_tick(2'b00, 2'b01, 2'b00);
    tick_wait(20);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
